// File: rtl/dividend_reconstructor.sv
`default_nettype none
// ============================================================================
// Module      : dividend_reconstructor
// Description : Rebuilds dividend = quotient*divisor + remainder with a
//               16-step shift-add multiplier and a final remainder add.
// Revision    : 1.0 - initial release
// ============================================================================
module dividend_reconstructor (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] quotient,
    input  logic [15:0] divisor,
    input  logic [15:0] remainder,
    output logic [31:0] result,
    output logic        overflow,
    output logic        valid_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    logic [47:0] r_acc;
    logic [47:0] r_mcand;
    logic [15:0] r_mplier;
    logic [15:0] r_rem;
    logic [3:0]  r_step;
    logic [31:0] r_result;
    logic        r_overflow;
    logic        r_valid_out;
    logic        r_busy;
    logic [47:0] w_sum;

    // A 32x16 product plus a 16-bit addend always fits in 48 bits.
    assign w_sum = r_acc + {32'b0, r_rem};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_acc       <= 48'b0;
            r_mcand     <= 48'b0;
            r_mplier    <= 16'b0;
            r_rem       <= 16'b0;
            r_step      <= 4'b0;
            r_result    <= 32'b0;
            r_overflow  <= 1'b0;
            r_valid_out <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        r_mcand  <= {16'b0, quotient};
                        r_mplier <= divisor;
                        r_rem    <= remainder;
                        r_acc    <= 48'b0;
                        r_step   <= 4'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= {r_mcand[46:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[15:1]};
                    r_step   <= r_step + 4'd1;
                    if (r_step == 4'd15) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result    <= w_sum[31:0];
                    r_overflow  <= |w_sum[47:32];
                    r_valid_out <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign result    = r_result;
    assign overflow  = r_overflow;
    assign valid_out = r_valid_out;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dividend_reconstructor.sv
`default_nettype none
// ============================================================================
// Module      : tb_dividend_reconstructor
// Description : Directed-vector bench for dividend_reconstructor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dividend_reconstructor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] quotient = 32'b0;
    logic [15:0] divisor = 16'b0;
    logic [15:0] remainder = 16'b0;
    logic [31:0] result;
    logic        overflow;
    logic        valid_out;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    dividend_reconstructor u_dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .result    (result),
        .overflow  (overflow),
        .valid_out (valid_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called #1 after the capture edge; returns edges to valid_out and busy cycles seen.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat = 0;
        busy_cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            if (valid_out) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_done(input string tag, input logic [63:0] exp, input int lat, input int bc);
        check({tag, "_latency"}, 64'(lat), 64'd17);
        check({tag, "_busy_cycles"}, 64'(bc), 64'd17);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
        check({tag, "_result"}, 64'(result), {32'b0, exp[31:0]});
        check({tag, "_overflow"}, 64'(overflow), 64'(|exp[47:32]));
    endtask

    task automatic run_op(input string tag, input logic [31:0] q, input logic [15:0] d,
                          input logic [15:0] r, input logic [63:0] exp);
        int lat;
        int bc;
        quotient  = q;
        divisor   = d;
        remainder = r;
        valid_in  = 1'b1;
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        quotient  = ~q;
        divisor   = ~d;
        remainder = ~r;
        wait_done(lat, bc);
        check_done(tag, exp, lat, bc);
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, 64'(valid_out), 64'd0);
        check({tag, "_hold"}, 64'(result), {32'b0, exp[31:0]});
    endtask

    initial begin
        int lat;
        int bc;
        int pulses;
        logic [31:0] rq;
        logic [15:0] rd;
        logic [15:0] rr;

        // Reset held with valid_in asserted must not start anything.
        valid_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", 64'(result), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        valid_in = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'd0);

        run_op("basic", 32'h0000_0007, 16'h0003, 16'h0002, 64'h17);
        run_op("mid", 32'h0001_0000, 16'h8000, 16'h7FFF, 64'h8000_7FFF);
        run_op("max", 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFE, 64'hFFFE_FFFF_FFFF);
        run_op("carry32", 32'hFFFF_FFFF, 16'h0001, 16'h0001, 64'h1_0000_0000);

        // Divisor zero, then valid_in held during busy and accepted in the pulse cycle.
        quotient  = 32'h1234_5678;
        divisor   = 16'h0000;
        remainder = 16'h00AB;
        valid_in  = 1'b1;
        @(posedge clk);
        #1;
        quotient  = 32'h1;
        divisor   = 16'h1;
        remainder = 16'h0;
        wait_done(lat, bc);
        check_done("div0", 64'hAB, lat, bc);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check("reacc_busy", 64'(busy), 64'd1);
        check("reacc_hold", 64'(result), 64'hAB);
        wait_done(lat, bc);
        check_done("reacc", 64'h1, lat, bc);

        // Asynchronous reset in the middle of an operation.
        run_op("pre_rst", 32'h0000_1000, 16'h0010, 16'h0003, 64'h1_0003);
        quotient  = 32'hFFFF_FFFF;
        divisor   = 16'hFFFF;
        remainder = 16'hFFFF;
        valid_in  = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_valid_out", 64'(valid_out), 64'd0);
        check("arst_result", 64'(result), 64'd0);
        check("arst_overflow", 64'(overflow), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (valid_out) pulses++;
        end
        check("arst_no_pulse", 64'(pulses), 64'd0);
        run_op("post_rst", 32'h0000_0064, 16'h000A, 16'h0005, 64'h3ED);

        // A handful of random operands against a wide software product.
        for (int i = 0; i < 40; i++) begin
            rq = $urandom;
            rd = 16'($urandom);
            rr = 16'($urandom);
            run_op($sformatf("rand%0d", i), rq, rd, rr,
                   64'(rq) * 64'(rd) + 64'(rr));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
